wb_commit_arbiter: RTL and testbench

WB_COMMIT_ARBITER -- requirements
Module: wb_commit_arbiter

---
 rtl/taiga_config.sv | 8 +
 rtl/taiga_types.sv | 7 +
 rtl/wb_commit_arbiter_pkg.sv | 7 +
 rtl/wb_rr_select.sv | 44 ++++
 rtl/wb_commit_arbiter.sv | 138 +++++++++++++
 tb/tb_wb_commit_arbiter.sv | 210 +++++++++++++++++++++
 6 files changed

// File: rtl/taiga_config.sv
// Build-wide sizing constants shared by the writeback/commit path.
package taiga_config;
    localparam int NUM_WB_UNITS_DEF = 4;
    localparam int COMMIT_PORTS_DEF = 2;
    localparam int DATA_W_DEF       = 32;
    localparam int ID_W_DEF         = 3;
    localparam int WB_UNITS_WIDTH   = (NUM_WB_UNITS_DEF > 1) ? $clog2(NUM_WB_UNITS_DEF) : 1;
endpackage

// File: rtl/taiga_types.sv
// Shared datatypes for the writeback/commit path.
package taiga_types;
    import taiga_config::*;

    typedef logic [ID_W_DEF-1:0]       id_t;
    typedef logic [WB_UNITS_WIDTH-1:0] wb_unit_idx_t;
endpackage

// File: rtl/wb_commit_arbiter_pkg.sv
// Helpers local to the commit arbiter and its unit picker.
package wb_commit_arbiter_pkg;
    // A one-unit configuration still needs a 1-bit index.
    function automatic int unit_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/wb_rr_select.sv
// Multi-grant priority picker: scans requesters from start_i (wrapping) and hands
// the first P requesters to ports 0..P-1 in scan order. Purely combinational.
module wb_rr_select #(
    parameter int N  = 4,
    parameter int P  = 2,
    parameter int IW = 2
) (
    input  logic [N-1:0]         req_i,
    input  logic [IW-1:0]        start_i,
    output logic [N-1:0]         gnt_o,
    output logic [P-1:0]         port_vld_o,
    output logic [P-1:0][IW-1:0] port_idx_o
);
    logic [IW:0]   sum;
    logic [IW-1:0] idx;
    int            cnt;

    always_comb begin
        gnt_o      = '0;
        port_vld_o = '0;
        port_idx_o = '0;
        sum        = '0;
        idx        = '0;
        cnt        = 0;
        for (int k = 0; k < N; k++) begin
            // One extra bit keeps start+k from overflowing before the modulo fold.
            sum = {1'b0, start_i} + (IW+1)'(k);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            idx = sum[IW-1:0];
            if (req_i[idx] && (cnt < P)) begin
                gnt_o[idx] = 1'b1;
                for (int p = 0; p < P; p++) begin
                    if (cnt == p) begin
                        port_vld_o[p] = 1'b1;
                        port_idx_o[p] = idx;
                    end
                end
                cnt = cnt + 1;
            end
        end
    end
endmodule

// File: rtl/wb_commit_arbiter.sv
// Writeback-to-commit arbiter with store-data forwarding; acks are same-cycle, retire
// outputs one cycle later; excess units stay unacked. Option: WB_ROUND_ROBIN_EN.
module wb_commit_arbiter
    import taiga_config::*;
    import wb_commit_arbiter_pkg::*;
#(
    parameter int NUM_WB_UNITS = NUM_WB_UNITS_DEF,
    parameter int COMMIT_PORTS = COMMIT_PORTS_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int ID_W         = ID_W_DEF
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_WB_UNITS-1:0]                unit_done,
    input  logic [NUM_WB_UNITS-1:0][ID_W-1:0]      unit_id,
    input  logic [NUM_WB_UNITS-1:0][DATA_W-1:0]    unit_rd,
    output logic [NUM_WB_UNITS-1:0]                unit_ack,
    output logic [COMMIT_PORTS-1:0]                retired,
    output logic [COMMIT_PORTS-1:0][ID_W-1:0]      ids_retiring,
    output logic [COMMIT_PORTS-1:0][DATA_W-1:0]    retiring_data,
    input  logic                                   store_waiting,
    input  logic [ID_W-1:0]                        store_id_needed,
    input  logic                                   store_ack,
    output logic                                   store_id_done,
    output logic [DATA_W-1:0]                      store_data
);
    localparam int UW = unit_idx_w(NUM_WB_UNITS);

    logic [NUM_WB_UNITS-1:0]             gnt;
    logic [COMMIT_PORTS-1:0]             port_vld;
    logic [COMMIT_PORTS-1:0][UW-1:0]     port_idx;
    logic [COMMIT_PORTS-1:0][ID_W-1:0]   port_id;
    logic [COMMIT_PORTS-1:0][DATA_W-1:0] port_dat;
    logic [UW-1:0]                       scan_start;

    logic [COMMIT_PORTS-1:0]             retired_q, retired_d;
    logic [COMMIT_PORTS-1:0][ID_W-1:0]   ids_q, ids_d;
    logic [COMMIT_PORTS-1:0][DATA_W-1:0] data_q, data_d;
    logic                                sdone_q, sdone_d;
    logic [DATA_W-1:0]                   sdata_q, sdata_d;
    logic                                store_hit;

    wb_rr_select #(
        .N  (NUM_WB_UNITS),
        .P  (COMMIT_PORTS),
        .IW (UW)
    ) u_select (
        .req_i      (unit_done),
        .start_i    (scan_start),
        .gnt_o      (gnt),
        .port_vld_o (port_vld),
        .port_idx_o (port_idx)
    );

`ifdef WB_ROUND_ROBIN_EN
    logic [UW-1:0] rr_ptr_q, rr_ptr_d;

    assign scan_start = rr_ptr_q;

    // Ports fill in scan order, so the highest valid port holds the last unit granted.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        for (int p = 0; p < COMMIT_PORTS; p++) begin
            if (port_vld[p]) begin
                rr_ptr_d = (port_idx[p] == UW'(NUM_WB_UNITS - 1)) ? '0 : port_idx[p] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    assign scan_start = '0;
`endif

    assign unit_ack = rst ? '0 : gnt;

    always_comb begin
        for (int p = 0; p < COMMIT_PORTS; p++) begin
            port_id[p]  = unit_id[port_idx[p]];
            port_dat[p] = unit_rd[port_idx[p]];
        end
    end

    // Idle ports drop their valid but keep the last retired id/data visible.
    always_comb begin
        retired_d = port_vld;
        ids_d     = ids_q;
        data_d    = data_q;
        for (int p = 0; p < COMMIT_PORTS; p++) begin
            if (port_vld[p]) begin
                ids_d[p]  = port_id[p];
                data_d[p] = port_dat[p];
            end
        end
    end

    // A fresh match overrides a same-cycle store_ack; lowest matching port wins.
    always_comb begin
        store_hit = 1'b0;
        sdone_d   = sdone_q & ~store_ack;
        sdata_d   = sdata_q;
        for (int p = 0; p < COMMIT_PORTS; p++) begin
            if (!store_hit && store_waiting && port_vld[p] && (port_id[p] == store_id_needed)) begin
                store_hit = 1'b1;
                sdone_d   = 1'b1;
                sdata_d   = port_dat[p];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retired_q <= '0;
            ids_q     <= '0;
            data_q    <= '0;
            sdone_q   <= 1'b0;
            sdata_q   <= '0;
        end else begin
            retired_q <= retired_d;
            ids_q     <= ids_d;
            data_q    <= data_d;
            sdone_q   <= sdone_d;
            sdata_q   <= sdata_d;
        end
    end

    assign retired       = retired_q;
    assign ids_retiring  = ids_q;
    assign retiring_data = data_q;
    assign store_id_done = sdone_q;
    assign store_data    = sdata_q;
endmodule

// File: tb/tb_wb_commit_arbiter.sv
// Directed vector bench for wb_commit_arbiter (default 4 units / 2 ports plus a 1-port instance).
module tb_wb_commit_arbiter;
    logic             clk;
    logic             rst;
    logic [3:0]       unit_done;
    logic [3:0][2:0]  unit_id;
    logic [3:0][31:0] unit_rd;
    logic             store_waiting;
    logic [2:0]       store_id_needed;
    logic             store_ack;

    logic [3:0]       unit_ack;
    logic [1:0]       retired;
    logic [1:0][2:0]  ids_retiring;
    logic [1:0][31:0] retiring_data;
    logic             store_id_done;
    logic [31:0]      store_data;

    logic [3:0]       ack1;
    logic [0:0]       ret1;
    logic [0:0][2:0]  ids1;
    logic [0:0][31:0] dat1;
    logic             sdone1;
    logic [31:0]      sdata1;

    int pass_cnt = 0;
    int total_cnt = 0;

    wb_commit_arbiter u_dut (
        .clk             (clk),
        .rst             (rst),
        .unit_done       (unit_done),
        .unit_id         (unit_id),
        .unit_rd         (unit_rd),
        .unit_ack        (unit_ack),
        .retired         (retired),
        .ids_retiring    (ids_retiring),
        .retiring_data   (retiring_data),
        .store_waiting   (store_waiting),
        .store_id_needed (store_id_needed),
        .store_ack       (store_ack),
        .store_id_done   (store_id_done),
        .store_data      (store_data)
    );

    wb_commit_arbiter #(.COMMIT_PORTS(1)) u_dut1 (
        .clk             (clk),
        .rst             (rst),
        .unit_done       (unit_done),
        .unit_id         (unit_id),
        .unit_rd         (unit_rd),
        .unit_ack        (ack1),
        .retired         (ret1),
        .ids_retiring    (ids1),
        .retiring_data   (dat1),
        .store_waiting   (store_waiting),
        .store_id_needed (store_id_needed),
        .store_ack       (store_ack),
        .store_id_done   (sdone1),
        .store_data      (sdata1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             r;
        logic [3:0]       done;
        logic [3:0][2:0]  id;
        logic [3:0][31:0] rd;
        logic             sw;
        logic [2:0]       need;
        logic             sack;
        logic [3:0]       eack;
        logic [1:0]       eret;
        logic [1:0][2:0]  eids;
        logic [1:0][31:0] edat;
        logic             esd;
        logic [31:0]      esdat;
    } vec_t;

    localparam int NV = 15;
    vec_t v [NV];

    function automatic vec_t mk(input logic r, input logic [3:0] done, input logic [3:0][2:0] id,
                                input logic [3:0][31:0] rd, input logic sw, input logic [2:0] need,
                                input logic sack, input logic [3:0] eack, input logic [1:0] eret,
                                input logic [1:0][2:0] eids, input logic [1:0][31:0] edat,
                                input logic esd, input logic [31:0] esdat);
        vec_t t;
        t.r = r; t.done = done; t.id = id; t.rd = rd; t.sw = sw; t.need = need; t.sack = sack;
        t.eack = eack; t.eret = eret; t.eids = eids; t.edat = edat; t.esd = esd; t.esdat = esdat;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        logic [3:0] exp_ack1 [3];
        logic [2:0] exp_id1  [3];

        rst = 1'b1; unit_done = '0; unit_id = '0; unit_rd = '0;
        store_waiting = 1'b0; store_id_needed = '0; store_ack = 1'b0;

        // Reset with all units done, overload, single unit, idle hold, store forwarding.
        v[0]  = mk(1'b1, 4'hF, {3'd4,3'd3,3'd2,3'd1}, {32'hA3,32'hA2,32'hA1,32'hA0}, 1'b1, 3'd1, 1'b0,
                   4'b0000, 2'b00, '0, '0, 1'b0, 32'h0);
        v[1]  = mk(1'b0, 4'hF, {3'd6,3'd3,3'd2,3'd1}, {32'h103,32'h102,32'h101,32'h100}, 1'b0, 3'd0, 1'b0,
                   4'b0011, 2'b11, {3'd2,3'd1}, {32'h101,32'h100}, 1'b0, 32'h0);
        v[2]  = mk(1'b0, 4'b1100, {3'd6,3'd3,3'd2,3'd1}, {32'h103,32'h102,32'h101,32'h100}, 1'b0, 3'd0, 1'b0,
                   4'b1100, 2'b11, {3'd6,3'd3}, {32'h103,32'h102}, 1'b0, 32'h0);
        v[3]  = mk(1'b0, 4'b0100, {3'd0,3'd5,3'd0,3'd0}, {32'h0,32'hDEADBEEF,32'h0,32'h0}, 1'b0, 3'd0, 1'b0,
                   4'b0100, 2'b01, {3'd6,3'd5}, {32'h103,32'hDEADBEEF}, 1'b0, 32'h0);
        v[4]  = mk(1'b0, 4'b0000, '0, '0, 1'b0, 3'd0, 1'b0,
                   4'b0000, 2'b00, {3'd6,3'd5}, {32'h103,32'hDEADBEEF}, 1'b0, 32'h0);
        v[5]  = mk(1'b0, 4'b0010, {3'd0,3'd0,3'd4,3'd0}, {32'h0,32'h0,32'h1234,32'h0}, 1'b1, 3'd4, 1'b0,
                   4'b0010, 2'b01, {3'd6,3'd4}, {32'h103,32'h1234}, 1'b1, 32'h1234);
        v[6]  = mk(1'b0, 4'b0010, {3'd0,3'd0,3'd4,3'd0}, {32'h0,32'h0,32'h55,32'h0}, 1'b1, 3'd4, 1'b1,
                   4'b0010, 2'b01, {3'd6,3'd4}, {32'h103,32'h55}, 1'b1, 32'h55);
        v[7]  = mk(1'b0, 4'b0000, '0, '0, 1'b1, 3'd4, 1'b0,
                   4'b0000, 2'b00, {3'd6,3'd4}, {32'h103,32'h55}, 1'b1, 32'h55);
        v[8]  = mk(1'b0, 4'b0000, '0, '0, 1'b0, 3'd4, 1'b1,
                   4'b0000, 2'b00, {3'd6,3'd4}, {32'h103,32'h55}, 1'b0, 32'h55);
        v[9]  = mk(1'b0, 4'b0011, {3'd0,3'd0,3'd3,3'd3}, {32'h0,32'h0,32'h701,32'h700}, 1'b1, 3'd3, 1'b0,
                   4'b0011, 2'b11, {3'd3,3'd3}, {32'h701,32'h700}, 1'b1, 32'h700);
        v[10] = mk(1'b0, 4'b0100, {3'd0,3'd1,3'd0,3'd0}, {32'h0,32'h800,32'h0,32'h0}, 1'b0, 3'd0, 1'b1,
                   4'b0100, 2'b01, {3'd3,3'd1}, {32'h701,32'h800}, 1'b0, 32'h700);
`ifdef WB_ROUND_ROBIN_EN
        v[11] = mk(1'b0, 4'b1001, {3'd7,3'd0,3'd0,3'd2}, {32'h300,32'h0,32'h0,32'h200}, 1'b0, 3'd0, 1'b0,
                   4'b1001, 2'b11, {3'd2,3'd7}, {32'h200,32'h300}, 1'b0, 32'h700);
        v[12] = mk(1'b0, 4'hF, {3'd4,3'd3,3'd2,3'd1}, {32'h13,32'h12,32'h11,32'h10}, 1'b0, 3'd0, 1'b0,
                   4'b0110, 2'b11, {3'd3,3'd2}, {32'h12,32'h11}, 1'b0, 32'h700);
`else
        v[11] = mk(1'b0, 4'b1001, {3'd7,3'd0,3'd0,3'd2}, {32'h300,32'h0,32'h0,32'h200}, 1'b0, 3'd0, 1'b0,
                   4'b1001, 2'b11, {3'd7,3'd2}, {32'h300,32'h200}, 1'b0, 32'h700);
        v[12] = mk(1'b0, 4'hF, {3'd4,3'd3,3'd2,3'd1}, {32'h13,32'h12,32'h11,32'h10}, 1'b0, 3'd0, 1'b0,
                   4'b0011, 2'b11, {3'd2,3'd1}, {32'h11,32'h10}, 1'b0, 32'h700);
`endif
        v[13] = mk(1'b1, 4'hF, {3'd4,3'd3,3'd2,3'd1}, {32'h13,32'h12,32'h11,32'h10}, 1'b1, 3'd2, 1'b0,
                   4'b0000, 2'b00, '0, '0, 1'b0, 32'h0);
        v[14] = mk(1'b0, 4'hF, {3'd4,3'd3,3'd2,3'd1}, {32'h13,32'h12,32'h11,32'h10}, 1'b0, 3'd0, 1'b0,
                   4'b0011, 2'b11, {3'd2,3'd1}, {32'h11,32'h10}, 1'b0, 32'h0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst = v[i].r; unit_done = v[i].done; unit_id = v[i].id; unit_rd = v[i].rd;
            store_waiting = v[i].sw; store_id_needed = v[i].need; store_ack = v[i].sack;
            #1;
            chk($sformatf("v%0d unit_ack", i), 64'(unit_ack), 64'(v[i].eack));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d retired", i), 64'(retired), 64'(v[i].eret));
            chk($sformatf("v%0d ids_retiring", i), 64'(ids_retiring), 64'(v[i].eids));
            chk($sformatf("v%0d retiring_data", i), 64'(retiring_data), 64'(v[i].edat));
            chk($sformatf("v%0d store_id_done", i), 64'(store_id_done), 64'(v[i].esd));
            chk($sformatf("v%0d store_data", i), 64'(store_data), 64'(v[i].esdat));
        end

        // Single-port instance: units 1 and 3 held done for three cycles after a reset.
`ifdef WB_ROUND_ROBIN_EN
        exp_ack1[0] = 4'b0010; exp_ack1[1] = 4'b1000; exp_ack1[2] = 4'b0010;
        exp_id1[0]  = 3'd2;    exp_id1[1]  = 3'd6;    exp_id1[2]  = 3'd2;
`else
        exp_ack1[0] = 4'b0010; exp_ack1[1] = 4'b0010; exp_ack1[2] = 4'b0010;
        exp_id1[0]  = 3'd2;    exp_id1[1]  = 3'd2;    exp_id1[2]  = 3'd2;
`endif
        @(negedge clk);
        rst = 1'b1; unit_done = '0; unit_id = '0; unit_rd = '0;
        store_waiting = 1'b0; store_ack = 1'b0; store_id_needed = '0;
        @(posedge clk);
        #1;
        chk("p1 reset retired", 64'(ret1), 64'(1'b0));

        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            rst = 1'b0; unit_done = 4'b1010;
            unit_id = {3'd6, 3'd0, 3'd2, 3'd0};
            unit_rd = {32'hB3, 32'h0, 32'hB1, 32'h0};
            #1;
            chk($sformatf("p1 c%0d unit_ack", c), 64'(ack1), 64'(exp_ack1[c]));
            @(posedge clk);
            #1;
            chk($sformatf("p1 c%0d retired", c), 64'(ret1), 64'(1'b1));
            chk($sformatf("p1 c%0d id", c), 64'(ids1), 64'(exp_id1[c]));
        end

        @(negedge clk);
        unit_done = 4'b1000;
        #1;
        chk("p1 drop unit_ack", 64'(ack1), 64'(4'b1000));
        @(posedge clk);
        #1;
        chk("p1 drop id", 64'(ids1), 64'(3'd6));
        chk("p1 drop data", 64'(dat1), 64'(32'hB3));
        chk("p1 store_id_done", 64'(sdone1), 64'(1'b0));
        chk("p1 store_data", 64'(sdata1), 64'(32'h0));

        @(negedge clk);
        unit_done = '0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
